// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt request unit.
// Bit positions follow the IF register layout at 0xFF0F.
package irq_pkg;

   localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;
   localparam logic [7:0]  IF_RST          = 8'h00;

   localparam int unsigned IRQ_VBLANK = 0;
   localparam int unsigned IRQ_STAT   = 1;
   localparam int unsigned IRQ_TIMER  = 2;
   localparam int unsigned IRQ_SERIAL = 3;
   localparam int unsigned IRQ_JOYPAD = 4;

   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_FALL = 1'b1
   } edge_pol_e;

endpackage

// File: rtl/irq_edge_det.sv
// Single-line edge detector with optional input synchronizer.
// Output is a combinational pulse from registered state, gated by en_i.
module irq_edge_det
   import irq_pkg::*;
#(
   parameter edge_pol_e   POL   = EDGE_RISE,
   parameter int unsigned DEPTH = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic sig_i,
   output logic set_pulse
);

   localparam logic IDLE = (POL == EDGE_FALL);

   logic cur;
   logic prev_q;

   generate
      if (DEPTH > 0) begin : g_sync
         logic [DEPTH-1:0] sync_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= sig_i;
               for (int k = 1; k < int'(DEPTH); k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign cur = sync_q[DEPTH-1];
      end else begin : g_nosync
         assign cur = sig_i;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= IDLE;
      end else begin
         prev_q <= cur;
      end
   end

   always_comb begin
      if (POL == EDGE_FALL) begin
         set_pulse = en_i & ~cur & prev_q;
      end else begin
         set_pulse = en_i & cur & ~prev_q;
      end
   end

endmodule

// File: rtl/irq_request_unit.sv
// IF register (0xFF0F): latches peripheral edges into level requests,
// retires them on ack rising edges, and is readable/writable by the CPU.
module irq_request_unit
   import irq_pkg::*;
#(
   parameter logic [15:0] IF_ADDR         = IF_ADDR_DEFAULT,
   parameter int unsigned NUM_SRC         = 5,
   parameter int unsigned JOY_SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        nRES,
   input  logic [15:0] A,
   input  logic [7:0]  D_IN,
   output logic [7:0]  D_OUT,
   input  logic        RD,
   input  logic        WR,
   output logic        IF_SEL,
   input  logic        SRC_VBLANK,
   input  logic        SRC_STAT,
   input  logic        SRC_TIMER,
   input  logic        SRC_SERIAL,
   input  logic [3:0]  JOY_n,
   input  logic [7:0]  CPU_IRQ_ACK,
   output logic [7:0]  CPU_IRQ_TRIG
);

   logic [NUM_SRC-1:0] if_q, if_d;
   logic [NUM_SRC-1:0] ack_prev_q;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] set;
   logic [4:0]         ev;
   logic [3:0]         joy_set;
   logic [3:0]         src_vec;
   logic               armed_q;
   logic               wr_en;
   logic               unused_ok;

   assign unused_ok = ^{D_IN[7:NUM_SRC], CPU_IRQ_ACK[7:NUM_SRC]};

   assign src_vec = {SRC_SERIAL, SRC_TIMER, SRC_STAT, SRC_VBLANK};

   // First clock after reset only loads prev flops; detection starts after.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_src
         irq_edge_det #(
            .POL   (EDGE_RISE),
            .DEPTH (0)
         ) u_src (
            .clk       (CLK),
            .rst_n     (nRES),
            .en_i      (armed_q),
            .sig_i     (src_vec[g]),
            .set_pulse (ev[g])
         );
      end

      for (g = 0; g < 4; g++) begin : g_joy
         irq_edge_det #(
            .POL   (EDGE_FALL),
            .DEPTH (JOY_SYNC_STAGES)
         ) u_joy (
            .clk       (CLK),
            .rst_n     (nRES),
            .en_i      (armed_q),
            .sig_i     (JOY_n[g]),
            .set_pulse (joy_set[g])
         );
      end
   endgenerate

   assign ev[IRQ_JOYPAD] = |joy_set;
   assign set            = ev[NUM_SRC-1:0];

   assign IF_SEL = (A == IF_ADDR);
   assign wr_en  = WR & IF_SEL;
   assign clr    = CPU_IRQ_ACK[NUM_SRC-1:0] & ~ack_prev_q;

   always_comb begin
      if_d = if_q;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (set[i]) begin
            if_d[i] = 1'b1;
         end else if (wr_en) begin
            if_d[i] = D_IN[i];
         end else if (clr[i]) begin
            if_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         if_q       <= IF_RST[NUM_SRC-1:0];
         ack_prev_q <= '0;
      end else begin
         if_q       <= if_d;
         ack_prev_q <= CPU_IRQ_ACK[NUM_SRC-1:0];
      end
   end

   assign CPU_IRQ_TRIG = {{(8-NUM_SRC){1'b0}}, if_q};

   always_comb begin
      D_OUT = 8'hFF;
      if (IF_SEL && RD) begin
         D_OUT = {{(8-NUM_SRC){1'b1}}, if_q};
      end
   end

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed scenarios followed by randomized traffic checked against a
// cycle-history model of the IF register rules.
module tb_irq_request_unit;

   localparam int NR = 400;

   logic        CLK = 1'b0;
   logic        nRES;
   logic [15:0] A;
   logic [7:0]  D_IN;
   logic [7:0]  D_OUT;
   logic        RD;
   logic        WR;
   logic        IF_SEL;
   logic        SRC_VBLANK;
   logic        SRC_STAT;
   logic        SRC_TIMER;
   logic        SRC_SERIAL;
   logic [3:0]  JOY_n;
   logic [7:0]  CPU_IRQ_ACK;
   logic [7:0]  CPU_IRQ_TRIG;

   int tests = 0;
   int fails = 0;

   logic [3:0]  src_h [0:NR-1];
   logic [3:0]  joy_h [0:NR-1];
   logic [7:0]  ack_h [0:NR-1];
   logic        wr_h  [0:NR-1];
   logic [15:0] a_h   [0:NR-1];
   logic [7:0]  d_h   [0:NR-1];
   logic [4:0]  mif;

   irq_request_unit dut (
      .CLK          (CLK),
      .nRES         (nRES),
      .A            (A),
      .D_IN         (D_IN),
      .D_OUT        (D_OUT),
      .RD           (RD),
      .WR           (WR),
      .IF_SEL       (IF_SEL),
      .SRC_VBLANK   (SRC_VBLANK),
      .SRC_STAT     (SRC_STAT),
      .SRC_TIMER    (SRC_TIMER),
      .SRC_SERIAL   (SRC_SERIAL),
      .JOY_n        (JOY_n),
      .CPU_IRQ_ACK  (CPU_IRQ_ACK),
      .CPU_IRQ_TRIG (CPU_IRQ_TRIG)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [3:0] pin(input int k);
      return (k < 0) ? 4'hF : joy_h[k];
   endfunction

   function automatic logic [7:0] ack_at(input int k);
      return (k < 0) ? 8'h00 : ack_h[k];
   endfunction

   initial begin
      logic [4:0] set_m;
      logic [7:0] clr_m;
      logic [3:0] sv;
      logic       wsel;

      nRES = 1'b0; A = 16'h0000; D_IN = 8'h00; RD = 1'b0; WR = 1'b0;
      SRC_VBLANK = 1'b0; SRC_STAT = 1'b0; SRC_TIMER = 1'b1;
      SRC_SERIAL = 1'b0; JOY_n = 4'hF; CPU_IRQ_ACK = 8'h00;
      mif = '0;

      // reset with a source held high
      tick(); tick();
      chk("rst_trig", CPU_IRQ_TRIG, 8'h00);
      chk("rst_dout", D_OUT, 8'hFF);
      nRES = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_trig", CPU_IRQ_TRIG, 8'h00);
      A = 16'hFF0F; RD = 1'b1; #1;
      chk("sel", {7'd0, IF_SEL}, 8'h01);
      chk("rd_reset", D_OUT, 8'hE0);
      RD = 1'b0;

      // timer request and held ack
      SRC_TIMER = 1'b0; tick();
      SRC_TIMER = 1'b1; tick();
      chk("timer_req", CPU_IRQ_TRIG, 8'h04);
      CPU_IRQ_ACK = 8'h04; tick();
      chk("timer_ack1", CPU_IRQ_TRIG, 8'h00);
      tick();
      chk("timer_ack2", CPU_IRQ_TRIG, 8'h00);
      tick();
      chk("timer_ack3", CPU_IRQ_TRIG, 8'h00);
      CPU_IRQ_ACK = 8'h00; SRC_TIMER = 1'b0; tick();

      // event coincident with ack rise
      CPU_IRQ_ACK = 8'h01; SRC_VBLANK = 1'b1; tick();
      chk("ev_ack", CPU_IRQ_TRIG, 8'h01);
      tick();
      chk("ev_ack_held", CPU_IRQ_TRIG, 8'h01);
      CPU_IRQ_ACK = 8'h00; tick();
      CPU_IRQ_ACK = 8'h01; tick();
      chk("vb_clr", CPU_IRQ_TRIG, 8'h00);
      CPU_IRQ_ACK = 8'h00; SRC_VBLANK = 1'b0;

      // software writes
      A = 16'hFF0F; D_IN = 8'hFF; WR = 1'b1; tick();
      WR = 1'b0;
      chk("wr_ff", CPU_IRQ_TRIG, 8'h1F);
      RD = 1'b1; #1;
      chk("rd_ff", D_OUT, 8'hFF);
      RD = 1'b0;
      D_IN = 8'h00; WR = 1'b1; SRC_STAT = 1'b1; tick();
      WR = 1'b0;
      chk("wr0_stat", CPU_IRQ_TRIG, 8'h02);
      CPU_IRQ_ACK = 8'h02; tick();
      CPU_IRQ_ACK = 8'h00; SRC_STAT = 1'b0;
      chk("stat_clr", CPU_IRQ_TRIG, 8'h00);
      A = 16'hFF0E; D_IN = 8'hFF; WR = 1'b1; #1;
      chk("nosel", {7'd0, IF_SEL}, 8'h00);
      tick();
      WR = 1'b0;
      chk("wr_other", CPU_IRQ_TRIG, 8'h00);

      // joypad latency through the synchronizer
      JOY_n = 4'b1011; tick();
      chk("joy_c1", CPU_IRQ_TRIG, 8'h00);
      tick();
      chk("joy_c2", CPU_IRQ_TRIG, 8'h00);
      tick();
      chk("joy_c3", CPU_IRQ_TRIG, 8'h10);
      JOY_n = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("joy_again", CPU_IRQ_TRIG, 8'h10);
      end
      CPU_IRQ_ACK = 8'h10; tick();
      chk("joy_ack", CPU_IRQ_TRIG, 8'h00);
      CPU_IRQ_ACK = 8'h00; JOY_n = 4'hF;
      tick(); tick(); tick(); tick();

      // async reset between edges
      SRC_TIMER = 1'b1; SRC_SERIAL = 1'b1; tick();
      chk("pre_async", CPU_IRQ_TRIG, 8'h0C);
      #2 nRES = 1'b0;
      #1 chk("async_rst", CPU_IRQ_TRIG, 8'h00);
      tick();
      nRES = 1'b1;
      tick(); tick(); tick();
      chk("held_after_rst", CPU_IRQ_TRIG, 8'h00);

      // randomized traffic against the history model
      nRES = 1'b0; tick();
      nRES = 1'b1;
      mif = '0;
      for (int n = 0; n < NR; n++) begin
         sv = {SRC_SERIAL, SRC_TIMER, SRC_STAT, SRC_VBLANK};
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) sv[b] = ~sv[b];
            if ($urandom_range(0, 7) == 0) JOY_n[b] = ~JOY_n[b];
         end
         {SRC_SERIAL, SRC_TIMER, SRC_STAT, SRC_VBLANK} = sv;
         CPU_IRQ_ACK = ($urandom_range(0, 2) == 0) ?
                       8'($urandom_range(0, 255)) : 8'h00;
         WR   = ($urandom_range(0, 4) == 0);
         A    = ($urandom_range(0, 1) == 0) ? 16'hFF0F :
                16'($urandom_range(0, 65535));
         D_IN = 8'($urandom_range(0, 255));
         RD   = 1'($urandom_range(0, 1));
         src_h[n] = sv; joy_h[n] = JOY_n; ack_h[n] = CPU_IRQ_ACK;
         wr_h[n] = WR; a_h[n] = A; d_h[n] = D_IN;
         #1;
         wsel = (A == 16'hFF0F);
         chk("r_sel", {7'd0, IF_SEL}, {7'd0, wsel});
         chk("r_dout", D_OUT, (wsel && RD) ? {3'b111, mif} : 8'hFF);
         @(posedge CLK);
         set_m = '0;
         if (n >= 1) begin
            set_m[3:0] = src_h[n] & ~src_h[n-1];
            set_m[4]   = |(~pin(n-2) & pin(n-3));
         end
         clr_m = ack_h[n] & ~ack_at(n-1);
         for (int b = 0; b < 5; b++) begin
            if (set_m[b]) mif[b] = 1'b1;
            else if (wr_h[n] && a_h[n] == 16'hFF0F) mif[b] = d_h[n][b];
            else if (clr_m[b]) mif[b] = 1'b0;
         end
         #1;
         chk("r_trig", CPU_IRQ_TRIG, {3'b000, mif});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
